// File: rtl/prog_counter.sv
// prog_counter -- parametrised fetch-path program counter.
//
// Holds the PC and a small hardware return stack. One action is taken per
// rising edge, chosen by fixed priority: clr > ret > call > ld > rel > inc > hold.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset (PC=RESET_VEC, stack empty, no error)
//   clr       synchronous clear of PC, stack pointer and stk_err
//   inc       PC <= PC + 1
//   ld        PC <= ld_addr
//   ld_addr   jump / call target
//   rel       PC <= PC + signed rel_off
//   rel_off   two's-complement branch offset
//   call      push PC+1, jump to ld_addr
//   ret       pop top of stack into PC
//   ep        drive PC onto pc_bus (otherwise high-Z)
//   pc_bus    tri-state PC for the shared bus
//   pc_q      always-driven PC copy
//   stk_full  stack holds STACK_DEPTH entries
//   stk_empty stack holds no entries
//   stk_err   sticky overflow/underflow flag, cleared by clr or rst
module prog_counter #(
    parameter int AW          = 4,
    parameter int RESET_VEC   = 0,
    parameter int STACK_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    input  logic          ld,
    input  logic [AW-1:0] ld_addr,
    input  logic          rel,
    input  logic [AW-1:0] rel_off,
    input  logic          call,
    input  logic          ret,
    input  logic          ep,
    output wire  [AW-1:0] pc_bus,
    output logic [AW-1:0] pc_q,
    output logic          stk_full,
    output logic          stk_empty,
    output logic          stk_err
);

    // sp counts occupied entries, so it must reach STACK_DEPTH itself.
    localparam int SPW = $clog2(STACK_DEPTH + 1);

    logic [AW-1:0]  pc, pc_nxt, pc_inc, top;
    logic [SPW-1:0] sp, sp_nxt;
    logic           err_nxt, push;
    logic [AW-1:0]  stack [STACK_DEPTH];

    assign pc_inc    = pc + 1'b1;
    assign stk_full  = (sp == SPW'(STACK_DEPTH));
    assign stk_empty = (sp == '0);
    assign pc_q      = pc;
    assign pc_bus    = ep ? pc : {AW{1'bz}};

    // Top-of-stack select; a compare loop keeps the index width exact for
    // any depth, including non-powers of two.
    always_comb begin
        top = stack[0];
        for (int i = 0; i < STACK_DEPTH; i++)
            if (sp == SPW'(i + 1)) top = stack[i];
    end

    always_comb begin
        pc_nxt  = pc;
        sp_nxt  = sp;
        err_nxt = stk_err;
        push    = 1'b0;
        if (clr) begin
            pc_nxt  = AW'(RESET_VEC);
            sp_nxt  = '0;
            err_nxt = 1'b0;
        end else if (ret) begin
            if (stk_empty) begin
                err_nxt = 1'b1;
            end else begin
                pc_nxt = top;
                sp_nxt = sp - 1'b1;
            end
        end else if (call) begin
            if (stk_full) begin
                err_nxt = 1'b1;
            end else begin
                push   = 1'b1;
                sp_nxt = sp + 1'b1;
                pc_nxt = ld_addr;
            end
        end else if (ld) begin
            pc_nxt = ld_addr;
        end else if (rel) begin
            // Truncating add mod 2^AW is identical to sign-extended addition.
            pc_nxt = pc + rel_off;
        end else if (inc) begin
            pc_nxt = pc_inc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= AW'(RESET_VEC);
            sp      <= '0;
            stk_err <= 1'b0;
        end else begin
            pc      <= pc_nxt;
            sp      <= sp_nxt;
            stk_err <= err_nxt;
        end
    end

    // Stack storage needs no reset: entries above sp are never read.
    always_ff @(posedge clk) begin
        if (push)
            for (int i = 0; i < STACK_DEPTH; i++)
                if (sp == SPW'(i)) stack[i] <= pc_inc;
    end

endmodule

// File: tb/tb_prog_counter.sv
// Bench for prog_counter with AW=4, RESET_VEC=5, STACK_DEPTH=4.
// A queue-based model tracks PC/stack/error; a compare process checks the DUT
// after every rising edge, and directed steps pin literal expectations.
module tb_prog_counter;

    localparam int AW = 4;
    localparam int RV = 5;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0, inc = 1'b0, ld = 1'b0, rel = 1'b0;
    logic          call = 1'b0, ret = 1'b0, ep = 1'b0;
    logic [AW-1:0] ld_addr = '0, rel_off = '0;
    wire  [AW-1:0] pc_bus;
    logic [AW-1:0] pc_q;
    logic          stk_full, stk_empty, stk_err;

    int pass_cnt = 0;
    int total    = 0;

    prog_counter #(.AW(AW), .RESET_VEC(RV), .STACK_DEPTH(SD)) dut (
        .clk(clk), .rst(rst), .clr(clr), .inc(inc), .ld(ld), .ld_addr(ld_addr),
        .rel(rel), .rel_off(rel_off), .call(call), .ret(ret), .ep(ep),
        .pc_bus(pc_bus), .pc_q(pc_q), .stk_full(stk_full),
        .stk_empty(stk_empty), .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    // Behavioural model: PC as an integer, return stack as a queue.
    int m_pc  = RV;
    int m_stk[$];
    bit m_err = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc = RV;
            m_stk.delete();
            m_err = 1'b0;
        end else if (clr) begin
            m_pc = RV;
            m_stk.delete();
            m_err = 1'b0;
        end else if (ret) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else m_err = 1'b1;
        end else if (call) begin
            if (m_stk.size() < SD) begin
                m_stk.push_back((m_pc + 1) % 16);
                m_pc = int'(ld_addr);
            end else m_err = 1'b1;
        end else if (ld) begin
            m_pc = int'(ld_addr);
        end else if (rel) begin
            int off;
            off  = (rel_off >= 4'd8) ? int'(rel_off) - 16 : int'(rel_off);
            m_pc = ((m_pc + off) % 16 + 16) % 16;
        end else if (inc) begin
            m_pc = (m_pc + 1) % 16;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    always @(posedge clk) begin
        #2;
        chk("model pc_q", int'(pc_q), m_pc);
        chk("model stk_empty", int'(stk_empty), int'(m_stk.size() == 0));
        chk("model stk_full", int'(stk_full), int'(m_stk.size() == SD));
        chk("model stk_err", int'(stk_err), int'(m_err));
        if (ep) chk("model pc_bus", int'(pc_bus), m_pc);
    end

    // Each step is applied at a falling edge and held for one rising edge.
    task automatic idle();
        clr = 0; inc = 0; ld = 0; rel = 0; call = 0; ret = 0;
    endtask
    task automatic step();
        @(negedge clk);
        idle();
    endtask
    task automatic t_ld(input logic [3:0] a);   ld = 1; ld_addr = a; step(); endtask
    task automatic t_inc();                     inc = 1; step(); endtask
    task automatic t_rel(input logic [3:0] o);  rel = 1; rel_off = o; step(); endtask
    task automatic t_call(input logic [3:0] a); call = 1; ld_addr = a; step(); endtask
    task automatic t_ret();                     ret = 1; step(); endtask
    task automatic t_clr();                     clr = 1; step(); endtask

    task automatic pulse_rst(input string name);
        #2 rst = 0;
        #1;
        chk({name, " pc_q"}, int'(pc_q), RV);
        chk({name, " stk_empty"}, int'(stk_empty), 1);
        chk({name, " stk_full"}, int'(stk_full), 0);
        chk({name, " stk_err"}, int'(stk_err), 0);
        #1 rst = 1;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("post-reset pc", int'(pc_q), RV);

        // Dirty the state, then reset asynchronously mid-cycle.
        t_call(8); t_ret(); t_ret(); t_ld(9);
        chk("pre-reset err", int'(stk_err), 1);
        pulse_rst("async reset");

        // Increment wrap with bus enabled.
        ep = 1;
        t_ld(14);
        t_inc(); chk("inc 15", int'(pc_q), 15); chk("bus 15", int'(pc_bus), 15);
        t_inc(); chk("inc wrap 0", int'(pc_q), 0); chk("bus 0", int'(pc_bus), 0);
        t_inc(); chk("inc 1", int'(pc_q), 1);

        // Relative branches.
        t_ld(2);
        t_rel(4'b1101); chk("rel -3", int'(pc_q), 15);
        t_rel(4'd3);    chk("rel +3", int'(pc_q), 2);
        t_rel(4'b1000); chk("rel -8", int'(pc_q), 10);

        // Nested call/return.
        ep = 0;
        t_ld(3);
        t_call(8); t_call(12);
        chk("call2 pc", int'(pc_q), 12);
        chk("call2 not empty", int'(stk_empty), 0);
        t_ret(); chk("ret1 pc", int'(pc_q), 9);
        t_ret(); chk("ret2 pc", int'(pc_q), 4);
        chk("ret2 empty", int'(stk_empty), 1);

        // Overflow, clear, underflow.
        t_call(1); t_call(2); t_call(3); t_call(4);
        chk("full", int'(stk_full), 1);
        t_call(7);
        chk("ovf pc hold", int'(pc_q), 4);
        chk("ovf err", int'(stk_err), 1);
        t_clr();
        chk("clr pc", int'(pc_q), RV);
        chk("clr err", int'(stk_err), 0);
        t_ret();
        chk("udf pc hold", int'(pc_q), RV);
        chk("udf err", int'(stk_err), 1);

        // Priority: ret beats call and inc.
        t_clr();
        t_call(9);
        ret = 1; call = 1; inc = 1; ld_addr = 4'd11; step();
        chk("prio ret pc", int'(pc_q), 6);
        chk("prio ret empty", int'(stk_empty), 1);
        chk("prio ret err", int'(stk_err), 0);
        clr = 1; ld = 1; ld_addr = 4'd10; step();
        chk("prio clr pc", int'(pc_q), RV);
        ld = 1; rel = 1; inc = 1; ld_addr = 4'd12; rel_off = 4'd1; step();
        chk("prio ld pc", int'(pc_q), 12);
        rel = 1; inc = 1; rel_off = 4'd2; step();
        chk("prio rel pc", int'(pc_q), 14);

        // Call followed directly by ret, then reset mid-chain.
        ep = 1;
        t_call(3); t_ret();
        chk("call-ret pc", int'(pc_q), 15);
        t_call(1); t_call(2);
        pulse_rst("reset mid-chain");
        t_ret();
        chk("post-reset ret err", int'(stk_err), 1);
        t_inc(); t_inc();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/prog_counter.md
# prog_counter

Parametrised program counter for the 8-bit CPU's fetch path, generalising the fixed 4-bit counter to any address width. Adds a programmable reset vector, absolute jump, signed relative branch and a hardware call/return stack with full/empty/error status. Drives the shared bus through a tri-state port under `ep` and also exposes an always-driven copy for debug.

## Interface
- `AW`, 4: address width in bits (≥2).
- `RESET_VEC`, 0: PC value after reset or `clr`.
- `STACK_DEPTH`, 4: return-stack entries (≥1).
- `clk` in 1: system clock, rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous clear of PC, stack pointer and `stk_err`.
- `inc` in 1: increment PC by 1.
- `ld` in 1: load PC from `ld_addr` (jump).
- `ld_addr` in AW: jump/call target.
- `rel` in 1: PC ← PC + sign-extended `rel_off`.
- `rel_off` in AW: two's-complement branch offset.
- `call` in 1: push PC+1, load `ld_addr`.
- `ret` in 1: pop top of stack into PC.
- `ep` in 1: enable PC onto bus.
- `pc_bus` out AW: PC when `ep`=1, else high-Z.
- `pc_q` out AW: PC, always driven.
- `stk_full` out 1: stack holds STACK_DEPTH entries.
- `stk_empty` out 1: stack holds 0 entries.
- `stk_err` out 1: sticky overflow/underflow flag.

## Operation
- State: PC register (AW), stack array STACK_DEPTH×AW, stack pointer `sp` (0..STACK_DEPTH, counts occupied entries), `stk_err`.
- One action per cycle, fixed priority: `clr` > `ret` > `call` > `ld` > `rel` > `inc` > hold. Lower-priority requests in the same cycle are dropped, with no error.
- `clr`: PC←RESET_VEC, sp←0, stk_err←0. Stack contents don't-care.
- `ret` with sp>0: PC←stack[sp-1], sp←sp-1.
- `ret` with sp=0 (underflow): PC holds, sp holds, stk_err←1.
- `call` with sp<STACK_DEPTH: stack[sp]←PC+1 (mod 2^AW), sp←sp+1, PC←ld_addr.
- `call` with sp=STACK_DEPTH (overflow): no push, no jump, PC holds, stk_err←1.
- `ld`: PC←ld_addr.
- `rel`: PC←(PC + rel_off) mod 2^AW. rel_off is signed, range −2^(AW−1)..2^(AW−1)−1.
- `inc`: PC←(PC+1) mod 2^AW. The all-ones address wraps to 0.
- `stk_full` = (sp==STACK_DEPTH). `stk_empty` = (sp==0). Both are decoded combinationally from the registered sp.
- `stk_err` stays set until `clr` or `rst`.

## Timing
- `rst` low: PC=RESET_VEC, sp=0, stk_err=0 immediately, independent of `clk`. Outputs follow: pc_q=RESET_VEC, stk_empty=1, stk_full=0, pc_bus high-Z unless `ep`.
- Reset release is sampled at the next rising edge. Controls asserted in the first edge after `rst` rises act normally.
- All actions take effect at the rising edge where they are sampled high: one-cycle latency, no multi-cycle operations, no handshake.
- `pc_bus` and `pc_q` are combinational from the PC register. New PC is visible on the bus in the same cycle as the edge when `ep`=1.
- `ep` gates only the bus drive and never alters state.
- Reset mid-sequence (e.g. during call/ret chains) discards stack contents. No partial push is possible because pushes are single-edge.
- Call then ret on consecutive cycles is legal: the ret returns the address pushed one edge earlier.

## Test plan
- Reset: AW=4, RESET_VEC=5. Pulse `rst` low mid-cycle -> pc_q=5 without clock edge; stk_empty=1, stk_err=0; `ep`=0 -> pc_bus=Z.
- Increment wrap: from PC=14, `inc` for 3 edges -> 15, 0, 1. `ep`=1 -> pc_bus matches pc_q each cycle.
- Relative branch: PC=2, `rel_off`=4'b1101 (−3) -> PC=15. Then `rel_off`=3 -> PC=2.
- Call/return nesting, STACK_DEPTH=4: from PC=3, call 8 then call 12 -> PC=12, sp=2. First ret -> 9. Second ret -> 4, stk_empty=1.
- Overflow/underflow: 4 calls fill the stack (stk_full=1). 5th call -> PC unchanged, stk_err=1. `clr` -> PC=RESET_VEC, stk_err=0. `ret` on empty -> PC unchanged, stk_err=1.
- Priority: `ret`+`call`+`inc` together with sp=1, top=6 -> PC=6, sp=0, no push, stk_err unchanged. `clr`+`ld` -> PC=RESET_VEC.
